uart_peripheral: RTL
====================

# uart_peripheral

- 8N1 UART peripheral behind the memory controller's UART decode: the downstream consumer of `uart_tx_send`, and the producer of `uart_busy`, `uart_rx_flag` and `uart_rddata`.
- Serialises the low byte of the bus write data onto `tx_serial`.
- Deserialises `rx_serial` into a one-byte receive holding register with a ready flag; the CPU clears the flag through `uart_rx_clear`.
- Bit timing comes from a fixed clock-cycles-per-bit divider.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥4.
- `clk`  in  1: system clock. One clock domain; all logic is on its rising edge.
- `rst`  in  1: reset. Synchronous and active-high.
- `uart_tx_send`  in  1: one-cycle strobe that starts a transmission.
- `uart_wrdata`  in  32: bus write data. Bits [7:0] are the byte to send; [31:8] are ignored.
- `uart_rx_clear`  in  1: strobe that clears `uart_rx_flag`.
- `rx_serial`  in  1: asynchronous serial input, idle high.
- `tx_serial`  out  1: serial output, idle high.
- `uart_busy`  out  1: transmitter is not idle.
- `uart_rx_flag`  out  1: a received byte is pending.
- `uart_rddata`  out  32: `{24'b0, rx_byte}`.

## Operation
- Reset values:
  - `tx_serial`=1, `uart_busy`=0, `uart_rx_flag`=0, `uart_rddata`=0.
  - Both state machines go to IDLE; all counters go to 0.
  - Both synchroniser flops go to 1.
- Transmit FSM: TX_IDLE → TX_START → TX_DATA → TX_STOP → TX_IDLE.
  - TX_IDLE:
    - If `uart_tx_send`=1, latch `uart_wrdata[7:0]`, clear the bit counter and go to TX_START.
    - If `uart_tx_send` is asserted in any other state, it is ignored: no queueing, and the latched byte is not changed.
  - TX_START: drive `tx_serial`=0 for CLKS_PER_BIT cycles.
  - TX_DATA: drive bits 0..7, LSB first, CLKS_PER_BIT cycles each. A 3-bit index advances at the end of each bit.
  - TX_STOP: drive `tx_serial`=1 for CLKS_PER_BIT cycles, then return to TX_IDLE.
  - `uart_busy` = (state != TX_IDLE), registered.
  - `tx_serial` is registered: no combinational path from any input to it.
- Receive path:
  - `rx_serial` passes through a 2-flop synchroniser. Only the synchronised signal `rx_s` is used.
- Receive FSM: RX_IDLE → RX_START → RX_DATA → RX_STOP → RX_IDLE.
  - RX_IDLE: on `rx_s`=0, clear the counter and go to RX_START.
  - RX_START:
    - After CLKS_PER_BIT/2 cycles (integer division), sample `rx_s`.
    - If it is 0, this is the bit centre: clear the counter and go to RX_DATA.
    - If it is 1, this is a false start: go to RX_IDLE and change nothing else.
  - RX_DATA: every CLKS_PER_BIT cycles, sample `rx_s` into shift-register bit [index], LSB first. After bit 7, go to RX_STOP.
  - RX_STOP: after CLKS_PER_BIT cycles, sample `rx_s`.
    - If it is 1: copy the shift register to `rx_byte`, set `uart_rx_flag`, go to RX_IDLE.
    - If it is 0 (framing error): discard the byte, leave `rx_byte` and the flag unchanged, go to RX_IDLE.
- Flag rules:
  - `uart_rx_clear` in a cycle with no byte completing: the flag is 0 on the next cycle.
  - A byte completes while the flag is already 1 (overrun): `rx_byte` is overwritten and the flag stays 1. No error indication.
  - A byte completes in the same cycle as `uart_rx_clear`: set wins. The flag stays 1 and `rx_byte` holds the new byte.
  - `uart_rx_clear` never modifies `rx_byte`.
- TX and RX are fully independent. Loopback (`tx_serial` tied to `rx_serial`) must work.
- Counters: bit-time counter width is $clog2(CLKS_PER_BIT); bit index is 3 bits. Counters wrap only through explicit clearing, never by overflow.

## Timing
- Cycle N has `uart_tx_send`=1 with TX idle. From N+1:
  - `uart_busy`=1 and `tx_serial`=0.
  - Data bit k is driven during [N+1+(k+1)·CLKS_PER_BIT, N+1+(k+2)·CLKS_PER_BIT).
  - The stop bit ends, and `uart_busy` falls, at N+1+10·CLKS_PER_BIT.
  - A new send is accepted in that cycle.
- Back-to-back transmit period: 10·CLKS_PER_BIT+1 cycles per byte.
- RX latency:
  - Start-bit falling edge on the pin at cycle E → `rx_s` low at E+2.
  - `uart_rx_flag` rises ≈ E+2+CLKS_PER_BIT/2+9·CLKS_PER_BIT+1, which is mid stop bit.
  - RX is back in RX_IDLE by then, so a following start bit is caught.
- Reset asserted mid-frame: everything returns to reset values on the next edge.
  - `tx_serial` returns to 1 immediately, truncating the frame.
  - A partially received byte is lost.
  - A start bit already in progress when reset releases is detected only if `rx_s` is still 0.

## Test plan
- Bench uses CLKS_PER_BIT=8.
- TX 0xA5:
  - Stimulus: `uart_tx_send` with `uart_wrdata`=0xFFFF_FFA5.
  - Required: `tx_serial` bits 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), 8 cycles each; `uart_busy` high for exactly 80 cycles.
- Send while busy:
  - Stimulus: second strobe with 0x3C at cycle N+20.
  - Required: ignored; the waveform still shows 0xA5 and no second frame follows.
- RX 0x5A then clear:
  - Stimulus: drive a 0x5A frame; pulse `uart_rx_clear` once `uart_rx_flag`=1.
  - Required: `uart_rddata`=0x0000_005A and flag=1; flag=0 one cycle after the clear; data unchanged.
- False start and framing error:
  - Stimulus: a 2-cycle low glitch, then a 0x81 frame with stop bit = 0.
  - Required: flag stays 0 and `uart_rddata` stays at its previous value.
- Overrun plus simultaneous clear:
  - Stimulus: receive 0x11 without clearing; receive 0x22 with `uart_rx_clear` asserted in its completion cycle.
  - Required: flag=1 and `uart_rddata`=0x22.
- Loopback and reset:
  - Stimulus: tie TX to RX and send 0x00 and 0xFF back-to-back; then assert `rst` mid-frame.
  - Required: both bytes are received correctly; after reset all outputs hold their reset values and `tx_serial`=1 on the next cycle.

Source files
------------

// File: rtl/uart_peripheral.sv
// uart_peripheral: 8N1 UART with a byte transmitter and a one-byte
// receive holding register whose ready flag the CPU clears.
module uart_peripheral #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_tx_send,
    input  logic [31:0] uart_wrdata,
    input  logic        uart_rx_clear,
    input  logic        rx_serial,
    output logic        tx_serial,
    output logic        uart_busy,
    output logic        uart_rx_flag,
    output logic [31:0] uart_rddata
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_byte;

    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_byte;
    logic          rx_m;
    logic          rx_s;

    assign uart_rddata = {24'b0, rx_byte};

    // Transmit FSM; line and busy are registered so nothing reaches the pin combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_byte   <= '0;
            tx_serial <= 1'b1;
            uart_busy <= 1'b0;
        end else begin
            unique case (tx_state)
                TX_IDLE: begin
                    if (uart_tx_send) begin
                        tx_byte   <= uart_wrdata[7:0];
                        tx_cnt    <= '0;
                        tx_idx    <= '0;
                        tx_serial <= 1'b0;
                        uart_busy <= 1'b1;
                        tx_state  <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt    <= '0;
                        tx_serial <= tx_byte[0];
                        tx_state  <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == 3'd7) begin
                            tx_serial <= 1'b1;
                            tx_state  <= TX_STOP;
                        end else begin
                            tx_idx    <= tx_idx + 3'd1;
                            tx_serial <= tx_byte[tx_idx + 3'd1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt    <= '0;
                        uart_busy <= 1'b0;
                        tx_state  <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_state  <= TX_IDLE;
                    tx_serial <= 1'b1;
                    uart_busy <= 1'b0;
                end
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_serial;
            rx_s <= rx_m;
        end
    end

    // Receive FSM and holding register; a completing byte overrides a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_shift     <= '0;
            rx_byte      <= '0;
            uart_rx_flag <= 1'b0;
        end else begin
            if (uart_rx_clear) begin
                uart_rx_flag <= 1'b0;
            end
            unique case (rx_state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        if (!rx_s) begin
                            rx_cnt   <= '0;
                            rx_idx   <= '0;
                            rx_state <= RX_DATA;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt           <= '0;
                        rx_shift[rx_idx] <= rx_s;
                        if (rx_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_idx <= rx_idx + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s) begin
                            rx_byte      <= rx_shift;
                            uart_rx_flag <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule
